// File: rtl/ppu_reg_if.sv
// ppu_reg_if: CPU<->PPU register file ($2000-$2007), loopy v/t/x/w scroll regs,
// PPUDATA read buffer, OAM/palette ports and VRAM req/ack with timeout. Option: PPU_OPEN_BUS_EN.
module ppu_reg_if #(
    parameter int unsigned VRAM_AW     = 14,
    parameter int unsigned OAM_AW      = 8,
    parameter int unsigned PAL_AW      = 5,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cs_n,
    input  logic               we,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    output logic               cpu_ready,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_overflow,
    output logic               nmi_n,
    output logic [7:0]         ctrl_reg,
    output logic [7:0]         mask_reg,
    output logic [14:0]        v_addr,
    output logic [14:0]        t_addr,
    output logic [2:0]         fine_x,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_req,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    input  logic               vram_ack,
    output logic [PAL_AW-1:0]  pal_addr,
    output logic               pal_we,
    output logic [7:0]         pal_wdata,
    input  logic [7:0]         pal_rdata,
    output logic [OAM_AW-1:0]  oam_addr,
    output logic               oam_we,
    output logic [7:0]         oam_wdata,
    input  logic [7:0]         oam_rdata
);
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t              r_state, state_nxt;
    logic                r_cs_n_q;
    logic [7:0]          r_ctrl, ctrl_nxt, r_mask, mask_nxt;
    logic [14:0]         r_v, v_nxt, r_t, t_nxt;
    logic [2:0]          r_fine_x, fine_x_nxt;
    logic                r_w, w_nxt, r_vblank, vblank_nxt, r_nmi_n, nmi_n_nxt;
    logic [7:0]          r_read_buf, read_buf_nxt, r_dout, dout_nxt;
    logic                r_ready, ready_nxt;
    logic [OAM_AW-1:0]   r_oam_addr, oam_addr_nxt;
    logic                r_oam_we, oam_we_nxt, r_oam_inc, oam_inc_nxt;
    logic [7:0]          r_oam_wdata, oam_wdata_nxt;
    logic                r_pal_we, pal_we_nxt, r_pal_inc, pal_inc_nxt;
    logic [7:0]          r_pal_wdata, pal_wdata_nxt;
    logic [VRAM_AW-1:0]  r_vram_addr, vram_addr_nxt;
    logic                r_req, req_nxt, r_vram_we, vram_we_nxt;
    logic [7:0]          r_vram_wdata, vram_wdata_nxt;
    logic [TW-1:0]       r_tmo, tmo_nxt;

    logic                w_strobe, w_is_pal, w_status_rd, w_busy_done;
    logic [14:0]         w_v_step;
    logic [4:0]          w_low5;
    logic [7:0]          w_wo_data;

`ifdef PPU_OPEN_BUS_EN
    logic [7:0]          r_io_latch, io_latch_nxt;
    assign w_low5    = r_io_latch[4:0];
    assign w_wo_data = r_io_latch;
`else
    assign w_low5    = 5'b0;
    assign w_wo_data = 8'h00;
`endif

    assign w_strobe    = r_cs_n_q & ~cs_n & (r_state == S_IDLE);
    assign w_is_pal    = (r_v[13:8] == 6'h3F);
    assign w_status_rd = w_strobe & ~we & (reg_addr == 3'd2);
    assign w_v_step    = r_ctrl[2] ? 15'd32 : 15'd1;
    assign w_busy_done = vram_ack | (r_tmo == TW'(ACK_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= state_nxt;
    end

    // Next-state and register-file update
    always_comb begin
        state_nxt      = r_state;
        ctrl_nxt       = r_ctrl;
        mask_nxt       = r_mask;
        v_nxt          = r_v;
        t_nxt          = r_t;
        fine_x_nxt     = r_fine_x;
        w_nxt          = r_w;
        read_buf_nxt   = r_read_buf;
        dout_nxt       = r_dout;
        ready_nxt      = r_ready;
        oam_addr_nxt   = r_oam_addr;
        oam_we_nxt     = 1'b0;
        oam_inc_nxt    = 1'b0;
        oam_wdata_nxt  = r_oam_wdata;
        pal_we_nxt     = 1'b0;
        pal_inc_nxt    = 1'b0;
        pal_wdata_nxt  = r_pal_wdata;
        vram_addr_nxt  = r_vram_addr;
        req_nxt        = r_req;
        vram_we_nxt    = r_vram_we;
        vram_wdata_nxt = r_vram_wdata;
        tmo_nxt        = r_tmo;
`ifdef PPU_OPEN_BUS_EN
        io_latch_nxt   = r_io_latch;
`endif
        // Deferred increments land the cycle after the pulse
        if (r_oam_inc) oam_addr_nxt = r_oam_addr + OAM_AW'(1);
        if (r_pal_inc) v_nxt = r_v + w_v_step;

        case (r_state)
            S_IDLE: begin
                if (w_strobe && we) begin
`ifdef PPU_OPEN_BUS_EN
                    io_latch_nxt = cpu_din;
`endif
                    case (reg_addr)
                        3'd0: begin
                            ctrl_nxt      = cpu_din;
                            t_nxt[11:10]  = cpu_din[1:0];
                        end
                        3'd1: mask_nxt = cpu_din;
                        3'd3: oam_addr_nxt = OAM_AW'(cpu_din);
                        3'd4: begin
                            oam_we_nxt    = 1'b1;
                            oam_wdata_nxt = cpu_din;
                            oam_inc_nxt   = 1'b1;
                        end
                        3'd5: begin
                            if (!r_w) begin
                                t_nxt[4:0] = cpu_din[7:3];
                                fine_x_nxt = cpu_din[2:0];
                            end else begin
                                t_nxt[14:12] = cpu_din[2:0];
                                t_nxt[9:5]   = cpu_din[7:3];
                            end
                            w_nxt = ~r_w;
                        end
                        3'd6: begin
                            if (!r_w) begin
                                t_nxt[13:8] = cpu_din[5:0];
                                t_nxt[14]   = 1'b0;
                            end else begin
                                t_nxt[7:0] = cpu_din;
                                v_nxt      = {r_t[14:8], cpu_din};
                            end
                            w_nxt = ~r_w;
                        end
                        3'd7: begin
                            if (w_is_pal) begin
                                pal_we_nxt    = 1'b1;
                                pal_wdata_nxt = cpu_din;
                                pal_inc_nxt   = 1'b1;
                            end else begin
                                state_nxt      = S_BUSY;
                                vram_addr_nxt  = VRAM_AW'(r_v);
                                vram_we_nxt    = 1'b1;
                                vram_wdata_nxt = cpu_din;
                                req_nxt        = 1'b1;
                                ready_nxt      = 1'b0;
                                tmo_nxt        = '0;
                            end
                        end
                        default: ;
                    endcase
                end else if (w_strobe) begin
                    case (reg_addr)
                        3'd2: begin
                            dout_nxt = {r_vblank, spr0_hit, spr_overflow, w_low5};
                            w_nxt    = 1'b0;
                        end
                        3'd4: dout_nxt = oam_rdata;
                        3'd7: begin
                            // Palette reads are immediate; the buffer refills from the mirrored nametable
                            dout_nxt      = w_is_pal ? pal_rdata : r_read_buf;
                            vram_addr_nxt = w_is_pal ? VRAM_AW'(r_v & 15'h2FFF) : VRAM_AW'(r_v);
                            state_nxt     = S_BUSY;
                            vram_we_nxt   = 1'b0;
                            req_nxt       = 1'b1;
                            ready_nxt     = 1'b0;
                            tmo_nxt       = '0;
                        end
                        default: dout_nxt = w_wo_data;
                    endcase
                end
            end
            S_BUSY: begin
                if (w_busy_done) begin
                    state_nxt   = S_IDLE;
                    req_nxt     = 1'b0;
                    ready_nxt   = 1'b1;
                    vram_we_nxt = 1'b0;
                    v_nxt       = r_v + w_v_step;
                    if (!r_vram_we) read_buf_nxt = vram_ack ? vram_rdata : 8'hFF;
                end else begin
                    tmo_nxt = r_tmo + TW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (vblank_clr)       vblank_nxt = 1'b0;
        else if (w_status_rd) vblank_nxt = 1'b0;
        else if (vblank_set)  vblank_nxt = 1'b1;
        else                  vblank_nxt = r_vblank;

        nmi_n_nxt = ~(ctrl_nxt[7] & vblank_nxt);
    end

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_n_q     <= 1'b1;
            r_ctrl       <= '0;
            r_mask       <= '0;
            r_v          <= '0;
            r_t          <= '0;
            r_fine_x     <= '0;
            r_w          <= 1'b0;
            r_vblank     <= 1'b0;
            r_nmi_n      <= 1'b1;
            r_read_buf   <= '0;
            r_dout       <= '0;
            r_ready      <= 1'b1;
            r_oam_addr   <= '0;
            r_oam_we     <= 1'b0;
            r_oam_inc    <= 1'b0;
            r_oam_wdata  <= '0;
            r_pal_we     <= 1'b0;
            r_pal_inc    <= 1'b0;
            r_pal_wdata  <= '0;
            r_vram_addr  <= '0;
            r_req        <= 1'b0;
            r_vram_we    <= 1'b0;
            r_vram_wdata <= '0;
            r_tmo        <= '0;
`ifdef PPU_OPEN_BUS_EN
            r_io_latch   <= '0;
`endif
        end else begin
            r_cs_n_q     <= cs_n;
            r_ctrl       <= ctrl_nxt;
            r_mask       <= mask_nxt;
            r_v          <= v_nxt;
            r_t          <= t_nxt;
            r_fine_x     <= fine_x_nxt;
            r_w          <= w_nxt;
            r_vblank     <= vblank_nxt;
            r_nmi_n      <= nmi_n_nxt;
            r_read_buf   <= read_buf_nxt;
            r_dout       <= dout_nxt;
            r_ready      <= ready_nxt;
            r_oam_addr   <= oam_addr_nxt;
            r_oam_we     <= oam_we_nxt;
            r_oam_inc    <= oam_inc_nxt;
            r_oam_wdata  <= oam_wdata_nxt;
            r_pal_we     <= pal_we_nxt;
            r_pal_inc    <= pal_inc_nxt;
            r_pal_wdata  <= pal_wdata_nxt;
            r_vram_addr  <= vram_addr_nxt;
            r_req        <= req_nxt;
            r_vram_we    <= vram_we_nxt;
            r_vram_wdata <= vram_wdata_nxt;
            r_tmo        <= tmo_nxt;
`ifdef PPU_OPEN_BUS_EN
            r_io_latch   <= io_latch_nxt;
`endif
        end
    end

    assign cpu_dout   = r_dout;
    assign cpu_ready  = r_ready;
    assign nmi_n      = r_nmi_n;
    assign ctrl_reg   = r_ctrl;
    assign mask_reg   = r_mask;
    assign v_addr     = r_v;
    assign t_addr     = r_t;
    assign fine_x     = r_fine_x;
    assign vram_addr  = r_vram_addr;
    assign vram_req   = r_req;
    assign vram_we    = r_vram_we;
    assign vram_wdata = r_vram_wdata;
    assign pal_addr   = r_v[PAL_AW-1:0];
    assign pal_we     = r_pal_we;
    assign pal_wdata  = r_pal_wdata;
    assign oam_addr   = r_oam_addr;
    assign oam_we     = r_oam_we;
    assign oam_wdata  = r_oam_wdata;

endmodule

// File: tb/tb_ppu_reg_if.sv
// Self-checking bench for ppu_reg_if: scoreboard queues hold expected CPU read data and VRAM requests.
module tb_ppu_reg_if;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1, we = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [7:0]  cpu_din = '0, cpu_dout;
    logic        cpu_ready;
    logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit = 1'b0, spr_overflow = 1'b1;
    logic        nmi_n;
    logic [7:0]  ctrl_reg, mask_reg;
    logic [14:0] v_addr, t_addr;
    logic [2:0]  fine_x;
    logic [13:0] vram_addr;
    logic        vram_req, vram_we, vram_ack = 1'b0;
    logic [7:0]  vram_wdata, vram_rdata = '0;
    logic [4:0]  pal_addr;
    logic        pal_we;
    logic [7:0]  pal_wdata, pal_rdata = '0;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata, oam_rdata = '0;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [13:0] addr; logic we; logic [7:0] wdata; } vram_txn_t;
    vram_txn_t   vq[$];
    logic [7:0]  dq[$];
    vram_txn_t   vt;
    logic [7:0]  de;

    // Bench model of v and the PPUDATA read buffer
    logic [14:0] m_v = '0;
    logic [7:0]  m_buf = '0;

    always #5 clk = ~clk;

    ppu_reg_if dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .we(we), .reg_addr(reg_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit(spr0_hit),
        .spr_overflow(spr_overflow), .nmi_n(nmi_n), .ctrl_reg(ctrl_reg), .mask_reg(mask_reg),
        .v_addr(v_addr), .t_addr(t_addr), .fine_x(fine_x), .vram_addr(vram_addr),
        .vram_req(vram_req), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .vram_ack(vram_ack), .pal_addr(pal_addr), .pal_we(pal_we),
        .pal_wdata(pal_wdata), .pal_rdata(pal_rdata), .oam_addr(oam_addr), .oam_we(oam_we),
        .oam_wdata(oam_wdata), .oam_rdata(oam_rdata)
    );

    // One CPU access; returns at the negedge just after the strobe edge
    task automatic cpu_strobe(input logic w, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; we = w; reg_addr = a; cpu_din = d;
        @(posedge clk);
        @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic ack_vram(input logic [7:0] d);
        vram_rdata = d; vram_ack = 1'b1;
        @(negedge clk);
        vram_ack = 1'b0;
    endtask

    task automatic pulse_vblank(input logic clr);
        @(negedge clk);
        if (clr) vblank_clr = 1'b1; else vblank_set = 1'b1;
        @(negedge clk);
        vblank_clr = 1'b0; vblank_set = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", cpu_ready); end
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi: got %b exp 1", nmi_n); end
        checks++; if (vram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", vram_req); end
        checks++; if (v_addr !== 15'h0 || t_addr !== 15'h0 || ctrl_reg !== 8'h0 || cpu_dout !== 8'h0)
            begin errors++; $display("FAIL reset_regs: got v=%h t=%h ctrl=%h dout=%h exp 0", v_addr, t_addr, ctrl_reg, cpu_dout); end
        reset_n = 1'b1;
        dq.push_back(8'h00);
        cpu_strobe(1'b0, 3'd0, 8'h00);
        de = dq.pop_front();
        checks++; if (cpu_dout !== de) begin errors++; $display("FAIL wo_read: got %h exp %h", cpu_dout, de); end
    endtask

    task automatic test_vram_write;
        cpu_strobe(1'b1, 3'd6, 8'h21);
        cpu_strobe(1'b1, 3'd6, 8'h08);
        m_v = 15'h2108;
        checks++; if (v_addr !== m_v || t_addr !== 15'h2108) begin errors++; $display("FAIL addr_2006: got v=%h t=%h exp 2108", v_addr, t_addr); end
        vq.push_back('{addr: 14'h2108, we: 1'b1, wdata: 8'hAB});
        cpu_strobe(1'b1, 3'd7, 8'hAB);
        vt = vq.pop_front();
        checks++; if (vram_req !== 1'b1 || cpu_ready !== 1'b0) begin errors++; $display("FAIL wr_req: got req=%b ready=%b exp 1/0", vram_req, cpu_ready); end
        checks++; if (vram_addr !== vt.addr || vram_we !== vt.we || vram_wdata !== vt.wdata)
            begin errors++; $display("FAIL wr_txn: got %h/%b/%h exp %h/%b/%h", vram_addr, vram_we, vram_wdata, vt.addr, vt.we, vt.wdata); end
        ack_vram(8'h00);
        m_v = m_v + 15'd1;
        checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1 || v_addr !== m_v)
            begin errors++; $display("FAIL wr_done: got req=%b ready=%b v=%h exp 0/1/%h", vram_req, cpu_ready, v_addr, m_v); end
    endtask

    task automatic test_ppudata_read;
        logic [7:0] rd [2];
        rd[0] = 8'h11; rd[1] = 8'h22;
        cpu_strobe(1'b1, 3'd0, 8'h04);
        for (int i = 0; i < 2; i++) begin
            dq.push_back(m_buf);
            vq.push_back('{addr: m_v[13:0], we: 1'b0, wdata: 8'h00});
            cpu_strobe(1'b0, 3'd7, 8'h00);
            de = dq.pop_front();
            vt = vq.pop_front();
            checks++; if (cpu_dout !== de) begin errors++; $display("FAIL rd_dout%0d: got %h exp %h", i, cpu_dout, de); end
            checks++; if (vram_addr !== vt.addr || vram_we !== vt.we || vram_req !== 1'b1)
                begin errors++; $display("FAIL rd_txn%0d: got %h/%b/%b exp %h/0/1", i, vram_addr, vram_we, vram_req, vt.addr); end
            ack_vram(rd[i]);
            m_buf = rd[i];
            m_v = m_v + 15'd32;
            checks++; if (v_addr !== m_v) begin errors++; $display("FAIL rd_v%0d: got %h exp %h", i, v_addr, m_v); end
        end
    endtask

    task automatic test_vblank;
        pulse_vblank(1'b0);
        dq.push_back(8'hA0); dq.push_back(8'h20);
        for (int i = 0; i < 2; i++) begin
            cpu_strobe(1'b0, 3'd2, 8'h00);
            de = dq.pop_front();
            checks++; if (cpu_dout !== de) begin errors++; $display("FAIL status%0d: got %h exp %h", i, cpu_dout, de); end
        end
        // Read in the same cycle as vblank_set: read wins
        @(negedge clk);
        cs_n = 1'b0; we = 1'b0; reg_addr = 3'd2; vblank_set = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cs_n = 1'b1; vblank_set = 1'b0;
        checks++; if (cpu_dout !== 8'h20) begin errors++; $display("FAIL status_race: got %h exp 20", cpu_dout); end
        cpu_strobe(1'b0, 3'd2, 8'h00);
        checks++; if (cpu_dout !== 8'h20) begin errors++; $display("FAIL status_race_after: got %h exp 20", cpu_dout); end
        pulse_vblank(1'b0);
        pulse_vblank(1'b1);
        cpu_strobe(1'b0, 3'd2, 8'h00);
        checks++; if (cpu_dout !== 8'h20) begin errors++; $display("FAIL status_clr: got %h exp 20", cpu_dout); end
    endtask

    task automatic test_nmi;
        pulse_vblank(1'b0);
        checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL nmi_masked: got %b exp 1", nmi_n); end
        cpu_strobe(1'b1, 3'd0, 8'h84);
        checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL nmi_assert: got %b exp 0", nmi_n); end
        cpu_strobe(1'b0, 3'd2, 8'h00);
        checks++; if (nmi_n !== 1'b1 || cpu_dout !== 8'hA0) begin errors++; $display("FAIL nmi_release: got nmi=%b dout=%h exp 1/a0", nmi_n, cpu_dout); end
        cpu_strobe(1'b1, 3'd0, 8'h00);
    endtask

    task automatic test_timeout;
        int n;
        dq.push_back(m_buf);
        cpu_strobe(1'b0, 3'd7, 8'h00);
        de = dq.pop_front();
        checks++; if (cpu_dout !== de) begin errors++; $display("FAIL to_dout: got %h exp %h", cpu_dout, de); end
        n = 0;
        while (cpu_ready === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        m_v = m_v + 15'd1; m_buf = 8'hFF;
        checks++; if (n != 15) begin errors++; $display("FAIL to_cycles: got %0d exp 15", n); end
        checks++; if (vram_req !== 1'b0 || v_addr !== m_v) begin errors++; $display("FAIL to_exit: got req=%b v=%h exp 0/%h", vram_req, v_addr, m_v); end
        dq.push_back(m_buf);
        cpu_strobe(1'b0, 3'd7, 8'h00);
        de = dq.pop_front();
        checks++; if (cpu_dout !== de) begin errors++; $display("FAIL to_buf: got %h exp %h", cpu_dout, de); end
        ack_vram(8'h33);
    endtask

    task automatic test_reset_busy;
        cpu_strobe(1'b0, 3'd7, 8'h00);
        checks++; if (vram_req !== 1'b1) begin errors++; $display("FAIL rb_req: got %b exp 1", vram_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (vram_req !== 1'b0 || cpu_ready !== 1'b1 || v_addr !== 15'h0)
            begin errors++; $display("FAIL rb_async: got req=%b ready=%b v=%h exp 0/1/0", vram_req, cpu_ready, v_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        m_v = '0; m_buf = '0;
    endtask

    task automatic test_oam;
        cpu_strobe(1'b1, 3'd3, 8'hFF);
        cpu_strobe(1'b1, 3'd4, 8'h5A);
        checks++; if (oam_we !== 1'b1 || oam_addr !== 8'hFF || oam_wdata !== 8'h5A)
            begin errors++; $display("FAIL oam_wr: got we=%b a=%h d=%h exp 1/ff/5a", oam_we, oam_addr, oam_wdata); end
        @(negedge clk);
        checks++; if (oam_we !== 1'b0 || oam_addr !== 8'h00) begin errors++; $display("FAIL oam_wrap: got we=%b a=%h exp 0/00", oam_we, oam_addr); end
        oam_rdata = 8'hC3;
        dq.push_back(8'hC3);
        cpu_strobe(1'b0, 3'd4, 8'h00);
        de = dq.pop_front();
        checks++; if (cpu_dout !== de || oam_addr !== 8'h00) begin errors++; $display("FAIL oam_rd: got %h a=%h exp %h a=00", cpu_dout, oam_addr, de); end
    endtask

    task automatic test_palette;
        cpu_strobe(1'b1, 3'd6, 8'h3F);
        cpu_strobe(1'b1, 3'd6, 8'h01);
        cpu_strobe(1'b1, 3'd7, 8'h2D);
        checks++; if (pal_we !== 1'b1 || pal_addr !== 5'h01 || pal_wdata !== 8'h2D || vram_req !== 1'b0)
            begin errors++; $display("FAIL pal_wr: got we=%b a=%h d=%h req=%b exp 1/01/2d/0", pal_we, pal_addr, pal_wdata, vram_req); end
        @(negedge clk);
        checks++; if (pal_we !== 1'b0 || v_addr !== 15'h3F02) begin errors++; $display("FAIL pal_inc: got we=%b v=%h exp 0/3f02", pal_we, v_addr); end
        pal_rdata = 8'h17;
        dq.push_back(8'h17);
        vq.push_back('{addr: 14'h2F02, we: 1'b0, wdata: 8'h00});
        cpu_strobe(1'b0, 3'd7, 8'h00);
        de = dq.pop_front();
        vt = vq.pop_front();
        checks++; if (cpu_dout !== de) begin errors++; $display("FAIL pal_rd: got %h exp %h", cpu_dout, de); end
        checks++; if (vram_req !== 1'b1 || vram_addr !== vt.addr) begin errors++; $display("FAIL pal_mirror: got req=%b a=%h exp 1/%h", vram_req, vram_addr, vt.addr); end
        ack_vram(8'h44);
        checks++; if (v_addr !== 15'h3F03) begin errors++; $display("FAIL pal_rd_inc: got %h exp 3f03", v_addr); end
    endtask

    task automatic test_scroll;
        cpu_strobe(1'b1, 3'd5, 8'hAB);
        cpu_strobe(1'b1, 3'd5, 8'h5E);
        checks++; if (t_addr !== 15'h6D75 || fine_x !== 3'd3) begin errors++; $display("FAIL scroll: got t=%h x=%0d exp 6d75/3", t_addr, fine_x); end
    endtask

    initial begin
        test_reset();
        test_vram_write();
        test_ppudata_read();
        test_vblank();
        test_nmi();
        test_timeout();
        test_reset_busy();
        test_oam();
        test_palette();
        test_scroll();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
